// File: rtl/nco_freq_estimator.sv
// Frequency estimator: counts samples over PERIODS rising crossings and
// serially divides the NCO phase span by that count to recover the step word.
module nco_freq_estimator #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int ACC_SIZE     = 8,
   parameter int PERIODS      = 4,
   parameter int CNT_WIDTH    = 16,
   parameter int HYST         = 256
) (
   input  logic                           iclk,
   input  logic                           ireset,
   input  logic                           inCS,
   input  logic signed [SAMPLE_WIDTH-1:0] sample,
   output logic [ACC_SIZE-1:0]            step_est,
   output logic                           est_valid,
   output logic                           sat,
   output logic                           timeout,
   output logic                           busy
);

   localparam int PW    = $clog2(PERIODS);
   localparam int NUM_W = ACC_SIZE + 3 + PW;
   localparam int NW    = CNT_WIDTH + 1;
   localparam int RW    = CNT_WIDTH + 2;
   localparam int XW    = PW + 1;
   localparam int DW    = $clog2(NUM_W);

   localparam logic [1:0] S_SYNC  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_DIV   = 2'd2;

   localparam logic signed [SAMPLE_WIDTH-1:0] HI = SAMPLE_WIDTH'(HYST);
   localparam logic signed [SAMPLE_WIDTH-1:0] LO = -HI;
   localparam logic [ACC_SIZE-1:0] QMAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
   localparam logic [NUM_W-1:0] QMAX_W = NUM_W'(QMAX);
   localparam logic [XW-1:0] XEND = XW'(PERIODS);
   localparam logic [XW-1:0] X1   = XW'(1);
   localparam logic [CNT_WIDTH-1:0] C1 = CNT_WIDTH'(1);
   localparam logic [NW-1:0] N1   = NW'(1);
   localparam logic [DW-1:0] D1   = DW'(1);
   localparam logic [DW-1:0] DEND = DW'(NUM_W - 1);

   logic [1:0]           state_q, state_d;
   logic                 neg_q, neg_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [XW-1:0]        xings_q, xings_d;
   logic [NW-1:0]        n_q, n_d;
   logic [NW-1:0]        rem_q, rem_d;
   logic [NUM_W-2:0]     quo_q, quo_d;
   logic [DW-1:0]        dcnt_q, dcnt_d;
   logic [ACC_SIZE-1:0]  step_q, step_d;
   logic                 valid_q, valid_d;
   logic                 sat_q, sat_d;
   logic                 to_q, to_d;

   logic             acc, xing, ge, q_sat, dbit;
   logic [RW-1:0]    rem_sh, n_ext, rem_sub;
   logic [NW-1:0]    rem_nx;
   logic [NUM_W-1:0] quo_nx;

   assign acc  = ~inCS;
   assign xing = acc & neg_q & (sample >= HI);

   // The dividend is a single one at its MSB, so only the first bit is set.
   assign dbit    = (dcnt_q == '0);
   assign n_ext   = {1'b0, n_q};
   assign rem_sh  = {rem_q, dbit};
   assign ge      = rem_sh >= n_ext;
   assign rem_sub = rem_sh - n_ext;
   assign rem_nx  = ge ? rem_sub[NW-1:0] : rem_sh[NW-1:0];
   assign quo_nx  = {quo_q, ge};
   assign q_sat   = quo_nx > QMAX_W;

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      xings_d = xings_q;
      n_d     = n_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dcnt_d  = dcnt_q;
      step_d  = step_q;
      valid_d = 1'b0;
      sat_d   = sat_q;
      to_d    = to_q;

      if (acc) begin
         if (sample <= LO) neg_d = 1'b1;
         else if (xing)    neg_d = 1'b0;
      end

      case (state_q)
         S_SYNC: begin
            if (xing) begin
               state_d = S_COUNT;
               cnt_d   = '0;
               xings_d = '0;
            end
         end
         S_COUNT: begin
            if (acc) begin
               cnt_d = cnt_q + C1;
               if (xing) xings_d = xings_q + X1;
               if (xing && (xings_q + X1 == XEND)) begin
                  state_d = S_DIV;
                  n_d     = {1'b0, cnt_q} + N1;
                  rem_d   = '0;
                  quo_d   = '0;
                  dcnt_d  = '0;
               end else if (&cnt_q) begin
                  state_d = S_SYNC;
                  step_d  = '0;
                  sat_d   = 1'b0;
                  to_d    = 1'b1;
                  valid_d = 1'b1;
               end
            end
         end
         S_DIV: begin
            rem_d  = rem_nx;
            quo_d  = quo_nx[NUM_W-2:0];
            dcnt_d = dcnt_q + D1;
            if (dcnt_q == DEND) begin
               state_d = S_SYNC;
               valid_d = 1'b1;
               sat_d   = q_sat;
               to_d    = 1'b0;
               step_d  = q_sat ? QMAX : quo_nx[ACC_SIZE-1:0];
            end
         end
         default: state_d = S_SYNC;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         state_q <= S_SYNC;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         xings_q <= '0;
         n_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dcnt_q  <= '0;
         step_q  <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         xings_q <= xings_d;
         n_q     <= n_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dcnt_q  <= dcnt_d;
         step_q  <= step_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
         to_q    <= to_d;
      end
   end

   assign step_est  = step_q;
   assign est_valid = valid_q;
   assign sat       = sat_q;
   assign timeout   = to_q;
   assign busy      = (state_q != S_SYNC);

endmodule

// File: tb/tb_nco_freq_estimator.sv
// Randomized bench for nco_freq_estimator against a sample-level
// behavioural model of the crossing/window/division rules.
module tb_nco_freq_estimator;

   localparam int ACC   = 8;
   localparam int P     = 4;
   localparam int HY    = 256;
   localparam int NUM   = P << (ACC + 2);
   localparam int NUM_W = ACC + 3 + $clog2(P);
   localparam int QMAX  = (1 << (ACC - 1)) - 1;
   localparam int CMAX  = 65535;

   logic              iclk = 1'b0;
   logic              ireset = 1'b1;
   logic              inCS = 1'b1;
   logic signed [15:0] sample = '0;
   logic [7:0]        step_est;
   logic              est_valid, sat, timeout, busy;

   nco_freq_estimator dut (
      .iclk      (iclk),
      .ireset    (ireset),
      .inCS      (inCS),
      .sample    (sample),
      .step_est  (step_est),
      .est_valid (est_valid),
      .sat       (sat),
      .timeout   (timeout),
      .busy      (busy)
   );

   always #5 iclk = ~iclk;

   int n_chk = 0;
   int n_err = 0;
   bit started = 1'b0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
         if (n_err >= 30) begin
            $display("Simulation finished: %0d checks, %0d errors",
                     n_chk, n_err);
            $finish;
         end
      end
   endtask

   // stimulus generator: 0 sine, 1 square, 2 dc, 3 small alternating
   int gen_kind = 2;
   int gen_per  = 8;
   int gen_ph   = 0;
   int gen_amp  = 0;
   int cs_pct   = 0;

   function automatic logic signed [15:0] gen_val();
      int  v;
      real r;
      case (gen_kind)
         0: begin
            r = 16000.0 * $sin(6.283185307179586 *
                real'(gen_ph % gen_per) / real'(gen_per));
            v = $rtoi(r);
         end
         1: v = ((gen_ph % gen_per) < gen_per / 2) ? 16000 : -16000;
         3: v = ((gen_ph % 2) != 0) ? 100 : -100;
         default: v = gen_amp;
      endcase
      return 16'(v);
   endfunction

   // reference model, one step per clock edge
   int   m_mode = 0;
   bit   m_neg = 0;
   int   m_cnt = 0, m_x = 0, m_left = 0, m_N = 1;
   bit   m_acc, m_xg;
   int   m_s, m_q;
   logic [7:0] e_step = '0;
   bit   e_valid = 0, e_sat = 0, e_to = 0;

   always @(posedge iclk) begin
      if (ireset) begin
         m_mode = 0; m_neg = 0; m_cnt = 0; m_x = 0; m_left = 0;
         e_step = '0; e_valid = 0; e_sat = 0; e_to = 0;
      end else begin
         e_valid = 0;
         m_acc = !inCS;
         m_s   = int'(sample);
         m_xg  = m_acc && m_neg && (m_s >= HY);
         if (m_acc && m_s <= -HY) m_neg = 1;
         else if (m_xg)           m_neg = 0;
         case (m_mode)
            0: if (m_xg) begin
               m_mode = 1; m_cnt = 0; m_x = 0;
            end
            1: if (m_acc) begin
               m_cnt++;
               if (m_xg) m_x++;
               if (m_xg && m_x == P) begin
                  m_N = m_cnt; m_mode = 2; m_left = NUM_W;
               end else if (m_cnt > CMAX) begin
                  m_mode = 0; e_step = '0; e_sat = 0;
                  e_to = 1; e_valid = 1;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) begin
                  m_q    = NUM / m_N;
                  e_sat  = (m_q > QMAX);
                  e_step = 8'(e_sat ? QMAX : m_q);
                  e_to   = 0;
                  e_valid = 1;
                  m_mode = 0;
               end
            end
         endcase
      end
      if (!inCS) gen_ph++;
   end

   logic [9:0] est_q[$];

   function automatic logic [31:0] outs();
      return {20'd0, busy, est_valid, sat, timeout, step_est};
   endfunction

   always @(negedge iclk) begin
      if (started) begin
         check("outs", outs(),
               {20'd0, (m_mode != 0), e_valid, e_sat, e_to, e_step});
         if (est_valid) est_q.push_back({sat, timeout, step_est});
      end
   end

   function automatic logic [9:0] est_at(int i);
      if (i < est_q.size()) return est_q[i];
      return 10'h3ff;
   endfunction

   task automatic cyc(int n);
      repeat (n) begin
         @(negedge iclk);
         inCS   = ($urandom_range(99) < cs_pct);
         sample = gen_val();
      end
   endtask

   task automatic do_reset(string tag);
      @(negedge iclk);
      ireset = 1'b1;
      inCS   = 1'b1;
      @(negedge iclk);
      ireset = 1'b0;
      check(tag, outs(), 32'd0);
      est_q.delete();
   endtask

   task automatic set_gen(int kind, int per, int cs);
      gen_kind = kind;
      gen_per  = per;
      cs_pct   = cs;
      gen_ph   = $urandom_range(per - 1);
   endtask

   task automatic run_until(int n, int budget, string tag);
      int c = 0;
      while (est_q.size() < n && c < budget) begin
         cyc(1);
         c++;
      end
      check({tag, "_est"}, 32'(est_q.size() >= n), 32'd1);
   endtask

   task automatic wait_mode(int m, int budget, string tag);
      int c = 0;
      while (m_mode != m && c < budget) begin
         cyc(1);
         c++;
      end
      check(tag, 32'(c < budget), 32'd1);
   endtask

   initial begin
      int per, q;
      ireset = 1'b1;
      inCS   = 1'b1;
      sample = '0;
      repeat (2) @(negedge iclk);
      started = 1'b1;
      check("reset", outs(), 32'd0);
      ireset = 1'b0;

      do_reset("rst_sine8");
      set_gen(0, 128, 0);
      run_until(1, 1200, "sine8");
      check("sine8", 32'(est_at(0)), {22'd0, 2'b00, 8'd8});

      do_reset("rst_sq8");
      set_gen(1, 8, 0);
      run_until(1, 200, "sq8");
      check("sq8", 32'(est_at(0)), {22'd0, 2'b10, 8'd127});

      do_reset("rst_sq10");
      set_gen(1, 10, 0);
      run_until(1, 200, "sq10");
      check("sq10", 32'(est_at(0)), {22'd0, 2'b00, 8'd102});

      // period 13 lands a crossing on the last divide cycle
      do_reset("rst_sq13");
      set_gen(1, 13, 0);
      run_until(2, 400, "sq13");
      check("sq13_a", 32'(est_at(0)), {22'd0, 2'b00, 8'd78});
      check("sq13_b", 32'(est_at(1)), 32'(est_at(0)));

      for (int i = 0; i < 6; i++) begin
         per = $urandom_range(60, 4);
         do_reset("rst_rnd");
         set_gen(1, per, $urandom_range(60));
         run_until(1, 3000, "rnd");
         q = NUM / (P * per);
         check("rnd", 32'(est_at(0)),
               (q > QMAX) ? {22'd0, 2'b10, 8'(QMAX)} : {22'd0, 2'b00, 8'(q)});
      end

      do_reset("rst_sine1");
      set_gen(0, 1024, 50);
      run_until(1, 20000, "sine1");
      check("sine1", 32'(est_at(0)), {22'd0, 2'b00, 8'd1});

      do_reset("rst_midc0");
      set_gen(1, 10, 0);
      wait_mode(1, 100, "wait_count");
      cyc(7);
      do_reset("rst_midcount");
      wait_mode(2, 200, "wait_div");
      cyc(3);
      do_reset("rst_middiv");
      cyc(20);
      check("no_est_after_rst", 32'(est_q.size()), 32'd0);
      run_until(1, 200, "after_rst");
      check("after_rst", 32'(est_at(0)), {22'd0, 2'b00, 8'd102});

      do_reset("rst_small");
      set_gen(3, 2, 0);
      cyc(2000);
      check("small_est", 32'(est_q.size()), 32'd0);
      check("small_busy", 32'(busy), 32'd0);

      gen_kind = 2;
      gen_amp  = -16000;
      cyc(2);
      gen_amp  = 16000;
      run_until(1, 70000, "tmo");
      check("tmo", 32'(est_at(0)), {22'd0, 2'b01, 8'd0});

      cyc(3);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
